// File: rtl/pmem_line_adapter_pkg.sv
// Shared types and 256-bit line half helpers for the pmem line adapter.
package pmem_line_adapter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_mem_data;
  typedef logic [255:0] lc3b_pmem_data;
  typedef logic [10:0]  lc3b_pmem_tag;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lc3b_pla_state;

  function automatic lc3b_mem_data get_half(input lc3b_pmem_data line, input logic h);
    lc3b_mem_data r;
    if (h) begin
      r = line[255:128];
    end else begin
      r = line[127:0];
    end
    return r;
  endfunction

  function automatic lc3b_pmem_data put_half(input lc3b_pmem_data line, input logic h,
                                             input lc3b_mem_data d);
    lc3b_pmem_data r;
    r = line;
    if (h) begin
      r[255:128] = d;
    end else begin
      r[127:0] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/pmem_line_adapter_line_buffer.sv
// One-entry 256-bit line buffer: valid/tag/data with hit compare, half read and half merge.
module pmem_line_buffer
  import pmem_line_adapter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  lc3b_pmem_tag  query_tag,
  input  logic          query_half,
  output logic          hit,
  output lc3b_mem_data  rd_half,
  input  logic          load,
  input  lc3b_pmem_tag  load_tag,
  input  lc3b_pmem_data load_data,
  input  logic          merge,
  input  logic          merge_half,
  input  lc3b_mem_data  merge_data,
  input  logic          invalidate,
  output lc3b_pmem_data line
);

  logic          valid_q, valid_d;
  lc3b_pmem_tag  tag_q, tag_d;
  lc3b_pmem_data data_q, data_d;
  lc3b_pmem_data base_s;

  // A merge on the same edge as a load applies on top of the freshly loaded line.
  always_comb begin
    base_s  = load ? load_data : data_q;
    data_d  = merge ? put_half(base_s, merge_half, merge_data) : base_s;
    tag_d   = load ? load_tag : tag_q;
    valid_d = invalidate ? 1'b0 : (load ? 1'b1 : valid_q);
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= 11'd0;
      data_q  <= 256'd0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit     = valid_q && (tag_q == query_tag);
  assign rd_half = get_half(data_q, query_half);
  assign line    = data_q;

endmodule

// File: rtl/pmem_line_adapter.sv
// Bridges 128-bit cache-line requests to 256-bit physical memory lines through a
// one-entry line buffer; writes are read-modify-write and written through.
module pmem_line_adapter
  import pmem_line_adapter_pkg::*;
#(
  parameter bit BUFFER_ENABLE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  lc3b_word      mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_data  mem_wdata,
  output lc3b_mem_data  mem_rdata,
  output logic          mem_resp,
  output lc3b_word      pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_pmem_data pmem_wdata,
  input  lc3b_pmem_data pmem_rdata,
  input  logic          pmem_resp
);

  lc3b_pla_state state_q, state_d;
  logic [11:0]   addr_q, addr_d;
  logic          wr_q, wr_d;
  lc3b_mem_data  wdata_q, wdata_d;
  lc3b_mem_data  rdata_q, rdata_d;
  lc3b_word      paddr_q, paddr_d;

  logic          hit_s, load_s, merge_s, merge_half_s, invalidate_s;
  lc3b_mem_data  rd_half_s, merge_data_s;
  lc3b_pmem_data line_s;
  logic          unused_addr_s;

  assign unused_addr_s = ^mem_address[3:0];

  // Request decode and state sequencing; the live address only matters in IDLE.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    paddr_d      = paddr_q;
    load_s       = 1'b0;
    merge_s      = 1'b0;
    merge_half_s = addr_q[0];
    merge_data_s = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = mem_address[15:4];
          wr_d    = mem_write;
          wdata_d = mem_wdata;
          paddr_d = {mem_address[15:5], 5'b0};
          if (!hit_s) begin
            state_d = FETCH;
          end else if (mem_write) begin
            merge_s      = 1'b1;
            merge_half_s = mem_address[4];
            merge_data_s = mem_wdata;
            state_d      = WRITE;
          end else begin
            rdata_d = rd_half_s;
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (!pmem_resp) begin
          state_d = FETCH;
        end else if (wr_q) begin
          load_s  = 1'b1;
          merge_s = 1'b1;
          state_d = WRITE;
        end else begin
          load_s  = 1'b1;
          rdata_d = get_half(pmem_rdata, addr_q[0]);
          state_d = RESP;
        end
      end
      WRITE:   state_d = pmem_resp ? RESP : WRITE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With the buffer disabled, a fetched line still carries the write merge but never becomes valid.
  assign invalidate_s = load_s & ~BUFFER_ENABLE;

  pmem_line_buffer u_line_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .query_tag  (mem_address[15:5]),
    .query_half (mem_address[4]),
    .hit        (hit_s),
    .rd_half    (rd_half_s),
    .load       (load_s),
    .load_tag   (addr_q[11:1]),
    .load_data  (pmem_rdata),
    .merge      (merge_s),
    .merge_half (merge_half_s),
    .merge_data (merge_data_s),
    .invalidate (invalidate_s),
    .line       (line_s)
  );

  // FSM and latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 12'd0;
      wr_q    <= 1'b0;
      wdata_q <= 128'd0;
      rdata_q <= 128'd0;
      paddr_q <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      paddr_q <= paddr_d;
    end
  end

  assign mem_resp     = (state_q == RESP);
  assign pmem_read    = (state_q == FETCH);
  assign pmem_write   = (state_q == WRITE);
  assign mem_rdata    = rdata_q;
  assign pmem_address = paddr_q;
  assign pmem_wdata   = line_s;

endmodule

// File: doc/pmem_line_adapter.md
# pmem_line_adapter

Responds to the 128-bit line interface used by the L1/victim cache side and initiates 256-bit transactions on physical memory. Each 32-byte pmem line holds two 16-byte cache lines; address bit 4 selects the half. A one-entry 256-bit line buffer serves back-to-back accesses to the same pmem line without a pmem round trip. Writes use read-modify-write and are written through to pmem.

## Interface
- BUFFER_ENABLE, 1, 0 forces every access to miss; the buffer is never marked valid.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_address  in  16 (lc3b_word)  byte address; bits [3:0] ignored
- mem_read  in  1  read request, held until mem_resp
- mem_write  in  1  write request, held until mem_resp
- mem_wdata  in  128 (lc3b_mem_data)  write line
- mem_rdata  out  128 (lc3b_mem_data)  read line, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  16  {mem_address[15:5], 5'b0}
- pmem_read  out  1  held until pmem_resp
- pmem_write  out  1  held until pmem_resp
- pmem_wdata  out  256 (lc3b_pmem_data)  full merged line
- pmem_rdata  in  256 (lc3b_pmem_data)  sampled when pmem_resp=1 during FETCH
- pmem_resp  in  1  pmem completion

## Operation
- Buffer state: buf_valid, buf_tag = address[15:5] (11 bits), buf_data 256 bits.
- Hit: buf_valid and buf_tag == mem_address[15:5].
- Half select h = mem_address[4]: h=0 is bits [127:0], h=1 is bits [255:128].
- FSM states: IDLE, FETCH, WRITE, RESP.
- IDLE, no request: stay.
- IDLE, read and hit: load mem_rdata from the buffer half, then go to RESP.
- IDLE, read and miss: go to FETCH.
- IDLE, write and hit: merge mem_wdata into the buffer half, then go to WRITE.
- IDLE, write and miss: go to FETCH.
- FETCH: pmem_read=1. On pmem_resp, load buf_data with pmem_rdata, set buf_tag, and set buf_valid if BUFFER_ENABLE.
  - Read: load mem_rdata from the fetched half, then go to RESP.
  - Write: apply the merge on the same edge, then go to WRITE.
- WRITE: pmem_write=1 and pmem_wdata=buf_data. On pmem_resp, go to RESP.
- RESP: mem_resp=1 for exactly one cycle, then go to IDLE unconditionally.
- The request is latched in IDLE: address, op, wdata.
- mem_read and mem_write both set: treated as a write.
- pmem_resp outside FETCH or WRITE is ignored.
- When BUFFER_ENABLE=0, a write still merges through buf_data to form pmem_wdata, but buf_valid stays 0.

## Timing
- Reset (asynchronous, rst_n=0):
  - State returns to IDLE and buf_valid=0.
  - mem_resp, pmem_read and pmem_write are 0.
  - mem_rdata, pmem_wdata and pmem_address are 0.
  - An in-flight pmem transaction is abandoned; the same applies mid-FETCH or mid-WRITE.
- All outputs are registered or decoded from state only. There is no combinational path from a request input to any output.
- Latency, with request seen at edge 0 and P = pmem cycles:
  - Read hit: mem_resp in cycle 1.
  - Read miss: pmem_read from cycle 1, mem_resp 1 cycle after the pmem_resp edge.
  - Write hit: pmem_write from cycle 1, mem_resp 1 cycle after pmem_resp.
  - Write miss: FETCH (P), then WRITE (P), then RESP.
- The requester must deassert in the cycle after mem_resp. A request still high in IDLE is taken as a new request.
- mem_rdata holds its last value after RESP.

## Structure
- The shared types package gains:
  - enum lc3b_pla_state {IDLE, FETCH, WRITE, RESP};
  - typedef lc3b_pmem_tag logic [10:0];
- Sub-module pmem_line_buffer holds valid, tag and data, and provides:
  - the hit compare;
  - the half read mux;
  - the half merge;
  - load-full-line and invalidate ports.
- The FSM stays in pmem_line_adapter.

## Test plan
- Cold read of 0x1230:
  - pmem_read with pmem_address 0x1220; pmem returns line L after 3 cycles.
  - mem_rdata = L[255:128]; mem_resp is one pulse, 1 cycle after pmem_resp.
- Follow-up read of 0x1220 after the cold read: no pmem activity; mem_rdata = L[127:0] with mem_resp in cycle 1.
- Write 0xAAAA…A to 0x1220 while 0x1220 is buffered: pmem_wdata = {L[255:128], 0xAAAA…A}; RESP follows pmem_resp.
- Write to unbuffered 0x4010:
  - FETCH, then WRITE with the upper half replaced and lower half from the fetched line.
  - A subsequent read of 0x4000 hits the buffer.
- rst_n pulsed low mid-FETCH:
  - pmem_read drops immediately and all outputs are 0.
  - A re-read of the same address misses.
- BUFFER_ENABLE=0: two consecutive reads of 0x1230 each issue pmem_read. Stray pmem_resp in IDLE causes no mem_resp.
